// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter. Bytes written from the
// core's UART store path are queued and serialised LSB first with one start and
// one stop bit. Back-to-back frames are sent with no idle gap between them.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       sys_clk_i,
    input  logic       sys_rstn_i,
    input  logic       uart_wr_i,
    input  logic [7:0] uart_dat_i,
    output logic       uart_tx,
    output logic       fifo_full_o,
    output logic       fifo_empty_o,
    output logic       busy_o,
    output logic       overflow_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nx;
    logic [BAUD_W-1:0] baud_cnt, baud_nx;
    logic [2:0]        bit_idx, bit_nx;
    logic [7:0]        shift_reg, shift_nx;
    logic              tx_nx;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, rd_nx;
    logic [PTR_W-1:0]  wr_ptr, wr_nx;
    logic [CNT_W-1:0]  count, count_nx;

    logic              push;
    logic              pop;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // Serialiser next state, FIFO pop/push decisions and the next line value.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shift_nx = shift_reg;
        pop      = 1'b0;

        case (state)
            IDLE: begin
                baud_nx = '0;
                if (!fifo_empty_o) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    state_nx = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = DATA;
                end else begin
                    baud_nx = baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nx  = '0;
                    shift_nx = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_nx = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty_o) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // The line is registered from the next state so it never glitches.
        tx_nx = 1'b1;
        if (state_nx == START) begin
            tx_nx = 1'b0;
        end else if (state_nx == DATA) begin
            tx_nx = shift_nx[0];
        end

        // A write into a full FIFO is still accepted if a slot frees this edge.
        push  = uart_wr_i && (!fifo_full_o || pop);
        wr_nx = push ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_nx = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;

        count_nx = count;
        if (push && !pop) begin
            count_nx = count + CNT_ONE;
        end else if (!push && pop) begin
            count_nx = count - CNT_ONE;
        end
    end

    // Control state, pointers, registered flags and the serial line.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            uart_tx      <= 1'b1;
            fifo_full_o  <= 1'b0;
            fifo_empty_o <= 1'b1;
            busy_o       <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            state        <= state_nx;
            baud_cnt     <= baud_nx;
            bit_idx      <= bit_nx;
            rd_ptr       <= rd_nx;
            wr_ptr       <= wr_nx;
            count        <= count_nx;
            uart_tx      <= tx_nx;
            fifo_full_o  <= (count_nx == CNT_FULL);
            fifo_empty_o <= (count_nx == '0);
            busy_o       <= (state_nx != IDLE) || (count_nx != '0);
            overflow_o   <= overflow_o | (uart_wr_i & ~push);
        end
    end

    // Byte storage and shift register carry data only and need no reset.
    always_ff @(posedge sys_clk_i) begin
        shift_reg <= shift_nx;
        if (push) begin
            mem[wr_ptr] <= uart_dat_i;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized and directed bench for uart_tx_buffered with a
// queue-based reference model and a mid-bit sampling 8N1 line decoder.
module tb_uart_tx_buffered;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       sys_clk_i  = 1'b0;
    logic       sys_rstn_i = 1'b0;
    logic       uart_wr_i  = 1'b0;
    logic [7:0] uart_dat_i = 8'h00;
    logic       uart_tx;
    logic       fifo_full_o;
    logic       fifo_empty_o;
    logic       busy_o;
    logic       overflow_o;

    int checks      = 0;
    int failures    = 0;
    int busy_cycles = 0;
    int rst_epoch   = 0;

    // Reference model: queued bytes, byte on the line and cycles left in its frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur  = 8'h00;
    int         m_left = 0;
    logic       m_ovf  = 1'b0;
    logic [7:0] exp_rx[$];
    logic [7:0] got_rx[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rstn_i  (sys_rstn_i),
        .uart_wr_i   (uart_wr_i),
        .uart_dat_i  (uart_dat_i),
        .uart_tx     (uart_tx),
        .fifo_full_o (fifo_full_o),
        .fifo_empty_o(fifo_empty_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level from the position inside the current frame.
    function automatic logic exp_tx();
        int el;
        int slot;
        if (m_left == 0) return 1'b1;
        el   = FRAME - m_left;
        slot = el / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        logic pop;
        logic frame_end;
        logic accept;
        if (!sys_rstn_i) begin
            m_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
            rst_epoch++;
            return;
        end
        frame_end = (m_left == 1);
        pop       = (m_left == 0 || frame_end) && (m_q.size() != 0);
        accept    = uart_wr_i && (m_q.size() < DEPTH || pop);
        if (uart_wr_i && !accept) m_ovf = 1'b1;
        if (frame_end) exp_rx.push_back(m_cur);
        if (pop) begin
            m_cur  = m_q.pop_front();
            m_left = FRAME;
        end else if (m_left != 0) begin
            m_left = m_left - 1;
            if (frame_end) m_left = 0;
        end
        if (accept) m_q.push_back(uart_dat_i);
    endtask

    initial forever begin
        @(posedge sys_clk_i or negedge sys_rstn_i);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge sys_clk_i);
        check_eq("tx", 32'(uart_tx), 32'(exp_tx()));
        check_eq("empty", 32'(fifo_empty_o), 32'(m_q.size() == 0));
        check_eq("full", 32'(fifo_full_o), 32'(m_q.size() == DEPTH));
        check_eq("busy", 32'(busy_o), 32'((m_left != 0) || (m_q.size() != 0)));
        check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
        if (busy_o) busy_cycles++;
    end

    // 8N1 decoder sampling 1.5 cycles into each bit; frames cut by reset are dropped.
    initial forever begin
        int         ep;
        logic [7:0] b;
        logic       ok;
        @(negedge uart_tx);
        ep = rst_epoch;
        repeat (2) @(negedge sys_clk_i);
        ok = (uart_tx == 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge sys_clk_i);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge sys_clk_i);
        ok = ok && uart_tx;
        if (ep == rst_epoch) begin
            check_eq("rx_framing", 32'(ok), 32'(1));
            got_rx.push_back(b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive_cycle(input logic w, input logic [7:0] d);
        @(negedge sys_clk_i);
        uart_wr_i  = w;
        uart_dat_i = d;
    endtask

    task automatic do_reset();
        @(negedge sys_clk_i);
        #1;
        sys_rstn_i = 1'b0;
        uart_wr_i  = 1'b0;
        repeat (2) @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            drive_cycle(1'b0, 8'h00);
            if (!busy_o && m_left == 0 && m_q.size() == 0) break;
            n++;
        end
        if (n >= budget) check_eq("idle_timeout", 32'(busy_o), 32'(0));
    endtask

    initial begin
        int         n0;
        int         b0;
        int         lows;
        logic [9:0] pat;
        logic [7:0] sent[20];

        // Reset state
        repeat (3) @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;
        check_eq("rst_tx", 32'(uart_tx), 32'(1));
        check_eq("rst_empty", 32'(fifo_empty_o), 32'(1));
        check_eq("rst_full", 32'(fifo_full_o), 32'(0));
        check_eq("rst_busy", 32'(busy_o), 32'(0));
        check_eq("rst_ovf", 32'(overflow_o), 32'(0));

        // Single byte 0xA5: exact waveform and busy duration
        pat = {1'b1, 8'hA5, 1'b0};
        b0  = busy_cycles;
        drive_cycle(1'b1, 8'hA5);
        drive_cycle(1'b0, 8'h00);
        check_eq("t1_pre_start", 32'(uart_tx), 32'(1));
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < CPB; c++) begin
                drive_cycle(1'b0, 8'h00);
                check_eq("t1_wave", 32'(uart_tx), 32'(pat[s]));
            end
        end
        check_eq("t1_busy_last", 32'(busy_o), 32'(1));
        drive_cycle(1'b0, 8'h00);
        check_eq("t1_busy_end", 32'(busy_o), 32'(0));
        check_eq("t1_busy_len", 32'(busy_cycles - b0), 32'(1 + FRAME));

        // Five back-to-back writes fill the FIFO without loss
        b0 = busy_cycles;
        n0 = got_rx.size();
        for (int i = 1; i <= 5; i++) drive_cycle(1'b1, 8'(i));
        drive_cycle(1'b0, 8'h00);
        check_eq("t2_full", 32'(fifo_full_o), 32'(1));
        check_eq("t2_no_ovf", 32'(overflow_o), 32'(0));
        wait_idle(1000);
        check_eq("t2_busy_len", 32'(busy_cycles - b0), 32'(1 + 5 * FRAME));
        check_eq("t2_rx_count", 32'(got_rx.size() - n0), 32'(5));
        for (int i = 0; i < 5 && n0 + i < got_rx.size(); i++)
            check_eq("t2_rx_byte", 32'(got_rx[n0+i]), 32'(i + 1));

        // Six writes: the sixth is dropped and overflow sticks
        n0 = got_rx.size();
        for (int i = 1; i <= 6; i++) drive_cycle(1'b1, 8'(i));
        drive_cycle(1'b0, 8'h00);
        check_eq("t3_ovf_set", 32'(overflow_o), 32'(1));
        wait_idle(1000);
        check_eq("t3_ovf_sticky", 32'(overflow_o), 32'(1));
        check_eq("t3_rx_count", 32'(got_rx.size() - n0), 32'(5));
        for (int i = 0; i < 5 && n0 + i < got_rx.size(); i++)
            check_eq("t3_rx_byte", 32'(got_rx[n0+i]), 32'(i + 1));

        // Write into a full FIFO on the same edge as the stop-bit pop
        do_reset();
        check_eq("t4_ovf_cleared", 32'(overflow_o), 32'(0));
        n0 = got_rx.size();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'h10 + i));
        repeat (FRAME - 4) drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, 8'h15);
        check_eq("t4_full_before", 32'(fifo_full_o), 32'(1));
        drive_cycle(1'b0, 8'h00);
        check_eq("t4_full_after", 32'(fifo_full_o), 32'(1));
        check_eq("t4_no_ovf", 32'(overflow_o), 32'(0));
        wait_idle(1000);
        check_eq("t4_rx_count", 32'(got_rx.size() - n0), 32'(6));
        for (int i = 0; i < 6 && n0 + i < got_rx.size(); i++)
            check_eq("t4_rx_byte", 32'(got_rx[n0+i]), 32'(8'h10 + i));

        // Reset during the data bits of 0xFF with two bytes queued
        drive_cycle(1'b1, 8'hFF);
        drive_cycle(1'b1, 8'hAA);
        drive_cycle(1'b1, 8'hBB);
        repeat (15) drive_cycle(1'b0, 8'h00);
        check_eq("t5_queued", 32'(fifo_empty_o), 32'(0));
        #2;
        sys_rstn_i = 1'b0;
        #1;
        check_eq("t5_tx_abort", 32'(uart_tx), 32'(1));
        check_eq("t5_empty_abort", 32'(fifo_empty_o), 32'(1));
        check_eq("t5_busy_abort", 32'(busy_o), 32'(0));
        repeat (2) @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;
        n0   = got_rx.size();
        lows = 0;
        repeat (60) begin
            drive_cycle(1'b0, 8'h00);
            if (!uart_tx) lows++;
        end
        check_eq("t5_line_quiet", 32'(lows), 32'(0));
        check_eq("t5_no_frame", 32'(got_rx.size() - n0), 32'(0));

        // Twenty spaced random writes with pointer wrap, none dropped
        n0 = got_rx.size();
        for (int i = 0; i < 20; i++) begin
            for (int g = 0; g < 200 && m_q.size() >= DEPTH; g++) drive_cycle(1'b0, 8'h00);
            sent[i] = 8'($urandom);
            drive_cycle(1'b1, sent[i]);
            repeat ($urandom_range(0, 50)) drive_cycle(1'b0, 8'h00);
        end
        wait_idle(2000);
        check_eq("t6_no_ovf", 32'(overflow_o), 32'(0));
        check_eq("t6_rx_count", 32'(got_rx.size() - n0), 32'(20));
        for (int i = 0; i < 20 && n0 + i < got_rx.size(); i++)
            check_eq("t6_rx_byte", 32'(got_rx[n0+i]), 32'(sent[i]));

        // Random dense traffic including drops and same-edge push/pop
        repeat (120) drive_cycle(1'($urandom), 8'($urandom));
        wait_idle(2000);

        // Whole-run line contents against the model
        check_eq("rx_total", 32'(got_rx.size()), 32'(exp_rx.size()));
        for (int i = 0; i < got_rx.size() && i < exp_rx.size(); i++)
            check_eq("rx_order", 32'(got_rx[i]), 32'(exp_rx[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter that sits directly downstream of the core's UART store path.
- Accepts one byte per cycle when a store hits the UART address (write strobe plus the low 8 bits of the store data).
- Queues bytes in a FIFO and serialises them at a fixed bit period, so back-to-back stores from the single-cycle core are not lost while a frame is in flight.
- Drives the FPGA-level serial line.

Parameters:
- CLKS_PER_BIT, 434, system clock cycles per serial bit (50 MHz / 115200); legal range ≥2.
- FIFO_DEPTH, 16, number of byte entries; power of two, ≥2.

Ports:
- sys_clk_i  input  1  system clock; all state updates on the rising edge.
- sys_rstn_i  input  1  reset, asynchronous, active-low.
- uart_wr_i  input  1  write strobe; one byte pushed per cycle while high.
- uart_dat_i  input  8  byte to transmit; sampled when uart_wr_i=1.
- uart_tx  output  1  serial line; idle high.
- fifo_full_o  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty_o  output  1  FIFO holds 0 entries.
- busy_o  output  1  serialiser not IDLE or FIFO non-empty.
- overflow_o  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (async assert, sync release): uart_tx=1, fifo_empty_o=1, fifo_full_o=0, busy_o=0, overflow_o=0. Pointers, count, FSM and bit counters are cleared.
- Reset mid-frame aborts the frame immediately: uart_tx=1 asynchronously, all queued bytes are discarded.
- FIFO storage:
  - Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - Flags are registered and derived from the count.
- Push:
  - Occurs on an edge where uart_wr_i=1 and (count<FIFO_DEPTH or a pop occurs on the same edge).
  - Push and pop on the same edge: count unchanged, both pointers advance.
- Drop: uart_wr_i=1 while full with no same-edge pop. The byte is discarded and overflow_o is set to 1. It stays set until reset.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If fifo_empty_o=0, pop the head into an 8-bit shift register and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit 7 completes, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (zero idle gap). Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, is reloaded on every state/bit change, and never free-runs in IDLE.
- Frame timing:
  - Exactly 10*CLKS_PER_BIT cycles per frame.
  - Back-to-back frames are contiguous.
  - uart_tx is registered (glitch-free).
- Latency: for a write accepted on edge E0 with the FSM in IDLE and the FIFO empty, the pop happens on E1 and uart_tx falls on E1 (the edge following the push).
- Writes arriving during a frame never disturb the current frame.
- busy_o is registered-consistent: it deasserts on the same edge the FSM enters IDLE with the FIFO empty.

Test Plan:
- CLKS_PER_BIT=4, FIFO_DEPTH=4. Single write 0xA5 after reset -> uart_tx low 1 cycle after the push edge for 4 cycles. Then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. busy_o drops after 40 cycles of frame.
- Five consecutive writes 0x01..0x05 -> first popped immediately, remaining four fill the FIFO (fifo_full_o=1), no drop, overflow_o=0. Five contiguous frames totalling 200 cycles with no high gap between stop and start bits.
- Six consecutive writes with FIFO_DEPTH=4 -> sixth byte (0x06) dropped, overflow_o=1 and sticky. Line carries exactly 0x01..0x05.
- FIFO full and a write coinciding with the STOP-end pop -> write accepted, count stays 4, no overflow. Byte appears in order after the existing ones.
- Assert sys_rstn_i=0 during DATA of 0xFF with 2 bytes queued -> uart_tx=1 and fifo_empty_o=1 immediately. After release no frame is sent until a new write.
- 20 writes spread with gaps (pointer wrap past depth) -> all 20 bytes received in order by a bench-side 8N1 decoder sampling at mid-bit.
